// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM with retire counter
//
// Sequences each instruction FETCH..WRITEBACK, one datapath step per clock,
// stalling FETCH/MEMRD/MEMWR on mem_ready. Outputs are Moore-decoded from the
// current state, except FETCH pc_write/ir_write which follow mem_ready.
//
// Optional feature macro: MC_ILLEGAL_TRAP_EN
//   defined   : illegal opcode in DECODE parks the FSM in TRAP (sticky illegal_op)
//   undefined : illegal opcode retires as a NOP, illegal_op tied 0
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   opcode                     IR[31:26], sampled in DECODE only
//   mem_ready                  memory finished current read/write this cycle
//   pc_write, pc_write_cond    unconditional / branch-conditional PC load
//   branch_ne                  branch condition polarity (1: bne)
//   pc_src[1:0]                PC source: ALU, ALUOut, jump target
//   i_or_d                     memory address select
//   mem_read, mem_write        memory requests
//   ir_write                   IR load
//   reg_dst, mem_to_reg        writeback destination / data select
//   reg_write                  register file write enable
//   alu_src_a, alu_src_b[1:0]  ALU operand selects
//   alu_op[1:0]                ALU operation class
//   state[3:0]                 current state (debug)
//   instr_done                 pulse in the last cycle of each instruction
//   instr_count[CNT_W-1:0]     retired-instruction counter (wraps)
//   illegal_op                 sticky illegal-opcode flag
module multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                branch_ne,
    output logic [1:0]          pc_src,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [3:0]          state,
    output logic                instr_done,
    output logic [CNT_W-1:0]    instr_count,
    output logic                illegal_op
);

    localparam logic [3:0] S_RST    = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_RWB    = 4'd8;
    localparam logic [3:0] S_IEXEC  = 4'd9;
    localparam logic [3:0] S_IWB    = 4'd10;
    localparam logic [3:0] S_BRANCH = 4'd11;
    localparam logic [3:0] S_JUMP   = 4'd12;
    localparam logic [3:0] S_TRAP   = 4'd13;

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b000101);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(6'b001001);
    localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(6'b001100);
    localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(6'b001101);
    localparam logic [OPCODE_W-1:0] OP_SLTI = OPCODE_W'(6'b001010);

    logic [3:0]          r_state;
    logic [3:0]          w_next;
    logic [OPCODE_W-1:0] r_opcode;
    logic [CNT_W-1:0]    r_count;
    logic [3:0]          w_dispatch;
    logic                w_legal;

    // DECODE dispatch target for the live opcode; w_legal=0 marks illegal.
    always_comb begin
        w_dispatch = S_FETCH;
        w_legal    = 1'b1;
        case (opcode)
            OP_R:                                     w_dispatch = S_EXEC;
            OP_LW, OP_SW:                             w_dispatch = S_MEMADR;
            OP_BEQ, OP_BNE:                           w_dispatch = S_BRANCH;
            OP_J:                                     w_dispatch = S_JUMP;
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI: w_dispatch = S_IEXEC;
            default: begin
                w_legal = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
                w_dispatch = S_TRAP;
`else
                w_dispatch = S_FETCH;
`endif
            end
        endcase
    end

    always_comb begin
        w_next = S_RST;
        case (r_state)
            S_RST:    w_next = S_FETCH;
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: w_next = w_dispatch;
            // lw/sw split uses the opcode captured in DECODE, not the live bus
            S_MEMADR: w_next = (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_RWB;
            S_IEXEC:  w_next = S_IWB;
            S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: w_next = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:   w_next = S_TRAP;
`endif
            default:  w_next = S_RST;
        endcase
    end

    // Retire strobe: last committing cycle of each instruction.
    always_comb begin
        instr_done = 1'b0;
        case (r_state)
            S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: instr_done = 1'b1;
            S_MEMWR:  instr_done = mem_ready;
`ifndef MC_ILLEGAL_TRAP_EN
            S_DECODE: instr_done = ~w_legal;
`endif
            default:  instr_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_RST;
            r_opcode <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_opcode <= opcode;
            if (instr_done)
                r_count <= r_count + 1'b1;
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic r_illegal;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_illegal <= 1'b0;
        else if (r_state == S_DECODE && !w_legal)
            r_illegal <= 1'b1;
    end
    assign illegal_op = r_illegal;
`else
    assign illegal_op = 1'b0;
`endif

    assign state       = r_state;
    assign instr_count = r_count;

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_src        = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        case (r_state)
            S_FETCH: begin
                // PC+4 and IR load only on the edge the fetch completes
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
            end
            S_IWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                branch_ne     = (r_opcode == OP_BNE);
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
            default: ;
        endcase
    end

endmodule
